// File: rtl/counter_cmd_pkg.sv
// Shared types and defaults for the counter command stage.
package counter_cmd_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEFAULT_REPEAT_CYCLES   = 64;

  // Command FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Which button owns the current command
  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_LOAD = 2'd1,
    CMD_UP   = 2'd2,
    CMD_DOWN = 2'd3
  } cmd_e;

  // True when issuing cmd would push the counter past a limit
  function automatic logic limit_hit(cmd_e cmd, logic high, logic low);
    return ((cmd == CMD_UP) && high) || ((cmd == CMD_DOWN) && low);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-FF synchroniser, debounce counter, press detect.
// The stable level flips only after the synced input has differed from it
// for DEBOUNCE_CYCLES consecutive cycles; o_press pulses on a 0->1 flip.
module btn_debounce
  import counter_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             press_q;

  // Synchronise, count disagreement with the stable level, flip when it persists
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= i_raw;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        press_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign o_level = level_q;
  assign o_press = press_q;

endmodule

// File: rtl/counter_cmd_ctrl.sv
// Command stage for the up/down counter: debounces load/up/down buttons,
// arbitrates simultaneous presses, blocks commands at the counter limits and
// emits one-cycle, mutually exclusive command pulses.
// Optional feature: define CNT_AUTO_REPEAT_EN to re-issue up/down every
// REPEAT_CYCLES cycles while the button stays held.
module counter_cmd_ctrl
  import counter_cmd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 5,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_btn_load,
  input  logic                  i_btn_up,
  input  logic                  i_btn_down,
  input  logic [DATA_WIDTH-1:0] i_value,
  input  logic                  i_high,
  input  logic                  i_low,
  output logic [DATA_WIDTH-1:0] o_in,
  output logic                  o_load,
  output logic                  o_up,
  output logic                  o_down,
  output logic                  o_blocked
);

`ifdef CNT_AUTO_REPEAT_EN
  localparam bit AUTO_REPEAT = 1'b1;
`else
  localparam bit AUTO_REPEAT = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_HOLD  = HOLD;

  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

  logic lvl_load, lvl_up, lvl_down;
  logic prs_load, prs_up, prs_down;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_raw  (i_btn_load),
    .o_level(lvl_load),
    .o_press(prs_load)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_raw  (i_btn_up),
    .o_level(lvl_up),
    .o_press(prs_up)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_raw  (i_btn_down),
    .o_level(lvl_down),
    .o_press(prs_down)
  );

  logic [1:0]            state_q, state_d;
  cmd_e                  sel_q, sel_d;
  logic [REP_W-1:0]      rep_q, rep_d;
  logic [DATA_WIDTH-1:0] in_q, in_d;
  logic                  load_q, load_d, up_q, up_d, down_q, down_d, blk_q, blk_d;

  cmd_e req_sel;
  cmd_e issue_sel;
  logic do_issue;
  logic held;

  // Arbitrate same-cycle presses: load wins; up+down together is a conflict (CMD_NONE)
  always_comb begin
    req_sel = CMD_NONE;
    if (prs_load)                req_sel = CMD_LOAD;
    else if (prs_up && prs_down) req_sel = CMD_NONE;
    else if (prs_up)             req_sel = CMD_UP;
    else if (prs_down)           req_sel = CMD_DOWN;
  end

  // Stable level of whichever button owns the command in flight
  always_comb begin
    held = 1'b0;
    unique case (sel_q)
      CMD_LOAD: held = lvl_load;
      CMD_UP:   held = lvl_up;
      CMD_DOWN: held = lvl_down;
      CMD_NONE: held = lvl_up | lvl_down;
    endcase
  end

  // FSM next state, pulse generation, limit blocking and repeat timing
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rep_d     = rep_q;
    in_d      = in_q;
    load_d    = 1'b0;
    up_d      = 1'b0;
    down_d    = 1'b0;
    blk_d     = 1'b0;
    do_issue  = 1'b0;
    issue_sel = CMD_NONE;

    case (state_q)
      ST_IDLE: begin
        if (prs_load || prs_up || prs_down) begin
          state_d   = ST_ISSUE;
          sel_d     = req_sel;
          do_issue  = 1'b1;
          issue_sel = req_sel;
        end
      end
      ST_ISSUE: state_d = ST_HOLD;
      ST_HOLD: begin
        // Release takes priority over a coincident repeat tick
        if (!held) begin
          state_d = ST_IDLE;
        end else if (AUTO_REPEAT && (sel_q == CMD_UP || sel_q == CMD_DOWN) &&
                     rep_q == REP_MAX) begin
          do_issue  = 1'b1;
          issue_sel = sel_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_issue) begin
      if (issue_sel == CMD_LOAD) begin
        load_d = 1'b1;
        in_d   = i_value;
      end else if (issue_sel == CMD_NONE || limit_hit(issue_sel, i_high, i_low)) begin
        blk_d = 1'b1;
      end else if (issue_sel == CMD_UP) begin
        up_d = 1'b1;
      end else begin
        down_d = 1'b1;
      end
    end

    // Repeat phase is measured from the most recent pulse
    if (do_issue) begin
      rep_d = '0;
    end else if (AUTO_REPEAT && state_q != ST_IDLE) begin
      rep_d = rep_q + 1'b1;
    end
  end

  // State and registered outputs; reset discards anything pending
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      sel_q   <= CMD_NONE;
      rep_q   <= '0;
      in_q    <= '0;
      load_q  <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      blk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rep_q   <= rep_d;
      in_q    <= in_d;
      load_q  <= load_d;
      up_q    <= up_d;
      down_q  <= down_d;
      blk_q   <= blk_d;
    end
  end

  assign o_in      = in_q;
  assign o_load    = load_q;
  assign o_up      = up_q;
  assign o_down    = down_q;
  assign o_blocked = blk_q;

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Bench for counter_cmd_ctrl with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Expected pulses are queued with their cycle stamp as stimulus is driven;
// observed pulses are queued as they appear and both are drained per test.
module tb_counter_cmd_ctrl;

  localparam int unsigned DW = 5;

  typedef struct packed {
    logic [3:0] kind;  // {load, up, down, blocked}
    int         cyc;
    logic [4:0] val;
  } ev_t;

  localparam logic [3:0] K_LOAD = 4'b1000;
  localparam logic [3:0] K_UP   = 4'b0100;
  localparam logic [3:0] K_DOWN = 4'b0010;
  localparam logic [3:0] K_BLK  = 4'b0001;

  logic          clk = 1'b0;
  logic          rst, btn_load, btn_up, btn_down, high, low;
  logic [DW-1:0] value;
  logic [DW-1:0] o_in;
  logic          o_load, o_up, o_down, o_blocked;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  counter_cmd_ctrl #(
    .DATA_WIDTH     (DW),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (8)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_btn_load(btn_load),
    .i_btn_up  (btn_up),
    .i_btn_down(btn_down),
    .i_value   (value),
    .i_high    (high),
    .i_low     (low),
    .o_in      (o_in),
    .o_load    (o_load),
    .o_up      (o_up),
    .o_down    (o_down),
    .o_blocked (o_blocked)
  );

  always #5 clk = ~clk;

  // Advance n cycles, sampling 1ns after each edge and logging any pulse
  task automatic step(input int n);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (o_load || o_up || o_down || o_blocked) begin
        e.kind = {o_load, o_up, o_down, o_blocked};
        e.cyc  = cyc;
        e.val  = o_load ? o_in : 5'd0;
        obs_q.push_back(e);
      end
    end
  endtask

  task automatic expect_ev(input logic [3:0] kind, input int at, input logic [4:0] val);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_load = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    high = 1'b0; low = 1'b0; value = '0;
    step(3);
    total++; if (o_load !== 1'b0) begin bad++; $display("FAIL reset_load: got %b want 0", o_load); end
    total++; if (o_up !== 1'b0) begin bad++; $display("FAIL reset_up: got %b want 0", o_up); end
    total++; if (o_down !== 1'b0) begin bad++; $display("FAIL reset_down: got %b want 0", o_down); end
    total++; if (o_blocked !== 1'b0) begin bad++; $display("FAIL reset_blocked: got %b want 0", o_blocked); end
    total++; if (o_in !== 5'd0) begin bad++; $display("FAIL reset_in: got %0d want 0", o_in); end
    rst = 1'b0;
    step(2);
    obs_q.delete();
  endtask

  task automatic test_bounce();
    ev_t e, o;
    int  c;
    c = cyc;
    expect_ev(K_UP, c + 15, 5'd0);  // final rise at c+8, plus 7
    for (int k = 0; k < 5; k++) begin
      btn_up = (k % 2 == 0);
      step(2);
    end
    step(5);
    btn_up = 1'b0;
    step(12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL bounce: missing kind=%b cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL bounce: got kind=%b cyc=%0d val=%0d want kind=%b cyc=%0d val=%0d",
                   o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL bounce_extra: got %0d extra pulses want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_load();
    ev_t e, o;
    int  c;
    value = 5'd7;
    c = cyc;
    btn_load = 1'b1;
    expect_ev(K_LOAD, c + 7, 5'd7);
    step(7);
    value = 5'd3;
    step(2);
    total++; if (o_in !== 5'd7) begin bad++; $display("FAIL load_hold_in: got %0d want 7", o_in); end
    btn_load = 1'b0;
    step(12);
    total++; if (o_in !== 5'd7) begin bad++; $display("FAIL load_after_in: got %0d want 7", o_in); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL load: missing kind=%b cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL load: got kind=%b cyc=%0d val=%0d want kind=%b cyc=%0d val=%0d",
                   o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL load_extra: got %0d extra pulses want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_limit();
    ev_t e, o;
    int  c;
    high = 1'b1;
    c = cyc;
    btn_up = 1'b1;
    expect_ev(K_BLK, c + 7, 5'd0);
    step(7);
    btn_up = 1'b0;
    step(12);
    high = 1'b0;
    low  = 1'b1;
    c = cyc;
    btn_down = 1'b1;
    expect_ev(K_BLK, c + 7, 5'd0);
    step(7);
    btn_down = 1'b0;
    step(12);
    low = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL limit: missing kind=%b cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL limit: got kind=%b cyc=%0d val=%0d want kind=%b cyc=%0d val=%0d",
                   o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL limit_extra: got %0d extra pulses want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_conflict();
    ev_t e, o;
    int  c;
    c = cyc;
    btn_up = 1'b1; btn_down = 1'b1;
    expect_ev(K_BLK, c + 7, 5'd0);
    step(7);
    btn_up = 1'b0; btn_down = 1'b0;
    step(12);
    value = 5'd5;
    c = cyc;
    btn_load = 1'b1; btn_up = 1'b1;
    expect_ev(K_LOAD, c + 7, 5'd5);
    step(7);
    btn_load = 1'b0; btn_up = 1'b0;
    step(12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL conflict: missing kind=%b cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL conflict: got kind=%b cyc=%0d val=%0d want kind=%b cyc=%0d val=%0d",
                   o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL conflict_extra: got %0d extra pulses want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_hold();
    ev_t e, o;
    int  c;
    c = cyc;
    btn_down = 1'b1;
    expect_ev(K_DOWN, c + 7, 5'd0);
`ifdef CNT_AUTO_REPEAT_EN
    expect_ev(K_DOWN, c + 15, 5'd0);
    expect_ev(K_DOWN, c + 23, 5'd0);
    expect_ev(K_DOWN, c + 31, 5'd0);
`endif
    step(30);
    btn_down = 1'b0;
    step(12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL hold: missing kind=%b cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL hold: got kind=%b cyc=%0d val=%0d want kind=%b cyc=%0d val=%0d",
                   o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL hold_extra: got %0d extra pulses want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    ev_t e, o;
    int  c;
    c = cyc;
    btn_down = 1'b1;
    expect_ev(K_DOWN, c + 7, 5'd0);
    step(10);
    rst = 1'b1;
    step(1);
    total++; if (o_load !== 1'b0) begin bad++; $display("FAIL midrst_load: got %b want 0", o_load); end
    total++; if (o_up !== 1'b0) begin bad++; $display("FAIL midrst_up: got %b want 0", o_up); end
    total++; if (o_down !== 1'b0) begin bad++; $display("FAIL midrst_down: got %b want 0", o_down); end
    total++; if (o_blocked !== 1'b0) begin bad++; $display("FAIL midrst_blocked: got %b want 0", o_blocked); end
    total++; if (o_in !== 5'd0) begin bad++; $display("FAIL midrst_in: got %0d want 0", o_in); end
    rst = 1'b0;
    c = cyc;
    expect_ev(K_DOWN, c + 7, 5'd0);  // still-held button re-debounced as a new press
    step(7);
    btn_down = 1'b0;
    step(12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL reset_mid: missing kind=%b cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL reset_mid: got kind=%b cyc=%0d val=%0d want kind=%b cyc=%0d val=%0d",
                   o.kind, o.cyc, o.val, e.kind, e.cyc, e.val);
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL reset_mid_extra: got %0d extra pulses want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_load();
    test_limit();
    test_conflict();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
